// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline types: datapath widths, register-number width and the
// hazard-controller state encoding.
package pipe_ctrl_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int ADDR_WIDTH       = 32;
  localparam int INSN_WIDTH       = 32;
  localparam int REG_NUM_WIDTH    = 5;
  localparam int MEM_TIMEOUT_DFLT = 256;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } ctrlState_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// pipeline performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incEn,
  output logic [WIDTH-1:0] countOut
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  logic [WIDTH-1:0] countR;

  // count register, frozen once saturated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countR <= {WIDTH{1'b0}};
    end else if (incEn && (countR != ALL_ONE)) begin
      countR <= countR + ONE;
    end else begin
      countR <= countR;
    end
  end

  assign countOut = countR;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: resolves data-memory waits, taken branches and
// load-use hazards into stall/flush controls, with a sticky memory timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DFLT,
  parameter int PERF_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_NUM_WIDTH-1:0] IdRSIn,
  input  logic [REG_NUM_WIDTH-1:0] IdRTIn,
  input  logic                     IdUsesRSIn,
  input  logic                     IdUsesRTIn,
  input  logic                     ExIsLoadInsnIn,
  input  logic                     ExRfWrEnableIn,
  input  logic [REG_NUM_WIDTH-1:0] ExWrNumIn,
  input  logic                     MemAccessIn,
  input  logic                     DmemReadyIn,
  input  logic                     BrTakenIn,
  output logic                     PcStallOut,
  output logic                     IfIdStallOut,
  output logic                     IdExStallOut,
  output logic                     ExMemStallOut,
  output logic                     IfIdFlushOut,
  output logic                     IdExFlushOut,
  output logic                     ExMemFlushOut,
  output logic                     MemWbFlushOut,
  output logic                     BusErrOut,
  output logic [PERF_WIDTH-1:0]    StallCountOut,
  output logic [PERF_WIDTH-1:0]    FlushCountOut
);

  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [REG_NUM_WIDTH-1:0] REG_ZERO = {REG_NUM_WIDTH{1'b0}};

  ctrlState_t        state;
  ctrlState_t        stateNext;
  logic [WCNT_W-1:0] waitCnt;
  logic              busErrR;
  logic              memWait;
  logic              loadUse;
  logic              branchAct;

  assign memWait = MemAccessIn && !DmemReadyIn;
  assign loadUse = ExIsLoadInsnIn && ExRfWrEnableIn && (ExWrNumIn != REG_ZERO) &&
                   ((IdUsesRSIn && (IdRSIn == ExWrNumIn)) ||
                    (IdUsesRTIn && (IdRTIn == ExWrNumIn)));

  // state, wait counter and sticky bus error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      waitCnt <= {WCNT_W{1'b0}};
      busErrR <= 1'b0;
    end else begin
      state   <= stateNext;
      busErrR <= (stateNext == ERR);
      if ((state == WAIT) && (stateNext == WAIT)) begin
        waitCnt <= waitCnt + WCNT_ONE;
      end else begin
        waitCnt <= {WCNT_W{1'b0}};
      end
    end
  end

  // next-state logic; ERR is only left through reset
  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (memWait) begin
          stateNext = WAIT;
        end else begin
          stateNext = RUN;
        end
      end
      WAIT: begin
        if (!memWait) begin
          stateNext = RUN;
        end else if (waitCnt == WAIT_LAST) begin
          stateNext = ERR;
        end else begin
          stateNext = WAIT;
        end
      end
      ERR: begin
        stateNext = ERR;
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  // one action per cycle: memwait, then branch, then load-use
  always_comb begin
    PcStallOut    = 1'b0;
    IfIdStallOut  = 1'b0;
    IdExStallOut  = 1'b0;
    ExMemStallOut = 1'b0;
    IfIdFlushOut  = 1'b0;
    IdExFlushOut  = 1'b0;
    ExMemFlushOut = 1'b0;
    MemWbFlushOut = 1'b0;
    branchAct     = 1'b0;
    if (rst) begin
      case (state)
        RUN, WAIT: begin
          if (memWait) begin
            // the held MEM instruction re-presents BrTakenIn once released
            PcStallOut    = 1'b1;
            IfIdStallOut  = 1'b1;
            IdExStallOut  = 1'b1;
            ExMemStallOut = 1'b1;
            MemWbFlushOut = 1'b1;
          end else if (BrTakenIn) begin
            IfIdFlushOut  = 1'b1;
            IdExFlushOut  = 1'b1;
            ExMemFlushOut = 1'b1;
            branchAct     = 1'b1;
          end else if (loadUse) begin
            PcStallOut    = 1'b1;
            IfIdStallOut  = 1'b1;
            IdExFlushOut  = 1'b1;
          end else begin
            branchAct     = 1'b0;
          end
        end
        default: begin
          PcStallOut    = 1'b1;
          IfIdStallOut  = 1'b1;
          IdExStallOut  = 1'b1;
          ExMemStallOut = 1'b1;
          MemWbFlushOut = 1'b1;
        end
      endcase
    end else begin
      branchAct = 1'b0;
    end
  end

  assign BusErrOut = busErrR;

  sat_counter #(.WIDTH(PERF_WIDTH)) uStallCnt (
    .clk      (clk),
    .rst      (rst),
    .incEn    (PcStallOut),
    .countOut (StallCountOut)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) uFlushCnt (
    .clk      (clk),
    .rst      (rst),
    .incEn    (branchAct),
    .countOut (FlushCountOut)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors go through a
// scoreboard queue; performance counters follow a saturating model.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] IdRSIn, IdRTIn, ExWrNumIn;
  logic       IdUsesRSIn, IdUsesRTIn, ExIsLoadInsnIn, ExRfWrEnableIn;
  logic       MemAccessIn, DmemReadyIn, BrTakenIn;
  logic       PcStallOut, IfIdStallOut, IdExStallOut, ExMemStallOut;
  logic       IfIdFlushOut, IdExFlushOut, ExMemFlushOut, MemWbFlushOut;
  logic       BusErrOut;
  logic [3:0] StallCountOut, FlushCountOut;

  // {PcStall, IfIdStall, IdExStall, ExMemStall, IfIdFlush, IdExFlush, ExMemFlush, MemWbFlush}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_0100;
  localparam logic [7:0] BR   = 8'b0000_1110;
  localparam logic [7:0] MW   = 8'b1111_0001;

  int total = 0;
  int bad   = 0;
  logic [8:0] scb[$];
  logic [3:0] expStall = 4'd0;
  logic [3:0] expFlush = 4'd0;

  pipe_ctrl #(.MEM_TIMEOUT(4), .PERF_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .IdRSIn(IdRSIn), .IdRTIn(IdRTIn), .IdUsesRSIn(IdUsesRSIn), .IdUsesRTIn(IdUsesRTIn),
    .ExIsLoadInsnIn(ExIsLoadInsnIn), .ExRfWrEnableIn(ExRfWrEnableIn), .ExWrNumIn(ExWrNumIn),
    .MemAccessIn(MemAccessIn), .DmemReadyIn(DmemReadyIn), .BrTakenIn(BrTakenIn),
    .PcStallOut(PcStallOut), .IfIdStallOut(IfIdStallOut), .IdExStallOut(IdExStallOut),
    .ExMemStallOut(ExMemStallOut), .IfIdFlushOut(IfIdFlushOut), .IdExFlushOut(IdExFlushOut),
    .ExMemFlushOut(ExMemFlushOut), .MemWbFlushOut(MemWbFlushOut), .BusErrOut(BusErrOut),
    .StallCountOut(StallCountOut), .FlushCountOut(FlushCountOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare mid-low phase, advance model past posedge.
  task automatic step(input string tag, input logic r, input logic ma, input logic rdy,
                      input logic br, input logic ld, input logic [4:0] wn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic [7:0] ev, input logic eb);
    logic [8:0] got;
    logic [7:0] vec;
    rst = r; MemAccessIn = ma; DmemReadyIn = rdy; BrTakenIn = br;
    ExIsLoadInsnIn = ld; ExRfWrEnableIn = ld; ExWrNumIn = wn;
    IdRSIn = rs; IdRTIn = rt; IdUsesRSIn = urs; IdUsesRTIn = urt;
    scb.push_back({ev, eb});
    if (!r) begin
      expStall = 4'd0;
      expFlush = 4'd0;
    end
    #2;
    got = scb.pop_front();
    vec = {PcStallOut, IfIdStallOut, IdExStallOut, ExMemStallOut,
           IfIdFlushOut, IdExFlushOut, ExMemFlushOut, MemWbFlushOut};
    checkVal({tag, ".ctl"}, {1'b0, vec}, {1'b0, got[8:1]});
    checkVal({tag, ".buserr"}, {8'd0, BusErrOut}, {8'd0, got[0]});
    checkVal({tag, ".stallcnt"}, {5'd0, StallCountOut}, {5'd0, expStall});
    checkVal({tag, ".flushcnt"}, {5'd0, FlushCountOut}, {5'd0, expFlush});
    if (r) begin
      if (got[8] && (expStall != 4'hF)) expStall = expStall + 4'd1;
      if ((got[8:1] == BR) && (expFlush != 4'hF)) expFlush = expFlush + 4'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; MemAccessIn = 1'b0; DmemReadyIn = 1'b0; BrTakenIn = 1'b0;
    ExIsLoadInsnIn = 1'b0; ExRfWrEnableIn = 1'b0; ExWrNumIn = 5'd0;
    IdRSIn = 5'd0; IdRTIn = 5'd0; IdUsesRSIn = 1'b0; IdUsesRTIn = 1'b0;
    @(negedge clk);
    // reset masks every hazard input
    step("rst",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, NONE, 1'b0);
    step("idle",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    step("lu_rs",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, LU,   1'b0);
    step("lu_clr",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    step("lu_r0",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, NONE, 1'b0);
    step("lu_rt",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, LU,   1'b0);
    step("lu_nouse", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, NONE, 1'b0);
    step("br",       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, BR,   1'b0);
    step("br_lu",    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, BR,   1'b0);
    step("mw_br",    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MW,   1'b0);
    step("rel_br",   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, BR,   1'b0);
    step("idle2",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    step("rst2",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    // entry cycle plus three WAIT cycles, released in the ready cycle
    for (int i = 0; i < 4; i++)
      step("mw",     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MW,   1'b0);
    step("rdy",      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    step("after_rdy",1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    checkVal("stall4", {5'd0, StallCountOut}, 9'd4);
    // entry plus four WAIT cycles reaches the timeout of 4
    for (int i = 0; i < 5; i++)
      step("to",     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MW,   1'b0);
    step("err_idle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MW,   1'b1);
    step("err_br",   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, MW,   1'b1);
    step("rst3",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    step("post_err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    for (int i = 0; i < 20; i++)
      step("sat",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, LU,   1'b0);
    step("sat_end",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0);
    checkVal("stall_sat", {5'd0, StallCountOut}, 9'h00F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
